iram_fetch_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle-registered-read instruction RAM among NUM_CORES fetch units.
//  - Arbitration is round-robin; at most one grant is issued per cycle.
//  - Each granted fetch is tagged with its core index and carried through a 2-stage pipeline.
//  - Read data is broadcast to all cores, with a one-hot valid marking the owning core.
//  - Sits between the per-core fetch stages and the instruction RAM.

---
 rtl/iram_fetch_arbiter.sv | 111 +++++++++++
 tb/tb_iram_fetch_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// iram_fetch_arbiter
//
// Shares one single-port instruction RAM (1-cycle registered read) among
// NUM_CORES fetch units.  One round-robin grant per cycle; each granted fetch
// is tagged with its core index and follows the RAM through a 2-stage
// pipeline.  The RAM data is broadcast to every core and a one-hot rvalid
// names the core that owns it.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   req        in   [NUM_CORES]          per-core fetch request (held until granted)
//   req_addr   in   [NUM_CORES*ADDR_W]   per-core fetch address, core i at [i*ADDR_W +: ADDR_W]
//   flush      in   [NUM_CORES]          per-core kill of in-flight fetches
//   gnt        out  [NUM_CORES]          one-hot accept, combinational
//   iram_addr  out  [ADDR_W]             registered RAM address
//   iram_data  in   [DATA_W]             RAM read data
//   rdata      out  [DATA_W]             iram_data, broadcast to all cores
//   rvalid     out  [NUM_CORES]          one-hot, marks the owner of rdata
// ---------------------------------------------------------------------------
module iram_fetch_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES-1:0]        flush,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [ADDR_W-1:0]           iram_addr,
    input  logic [DATA_W-1:0]           iram_data,
    output logic [DATA_W-1:0]           rdata,
    output logic [NUM_CORES-1:0]        rvalid
);

    localparam int IDX_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0] eligible;
    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [ADDR_W-1:0]    winner_addr;

    logic [IDX_W-1:0]     rr_ptr;
    logic                 s1_vld;
    logic [IDX_W-1:0]     s1_tag;
    logic                 s2_vld;
    logic [IDX_W-1:0]     s2_tag;

    // Round-robin pick: scan upward from the core after the last winner,
    // wrapping, and take the first one that requests and is not being flushed.
    always_comb begin
        eligible = req & ~flush;
        found    = 1'b0;
        winner   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!found && eligible[(int'(rr_ptr) + k) % NUM_CORES]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
            end
        end
        winner_addr = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    end

    // No grant is advertised during reset, since the grant would not be
    // recorded by the pipeline and the core would lose its request.
    always_comb begin
        gnt = '0;
        if (found && !reset) begin
            gnt[winner] = 1'b1;
        end
    end

    // Stage 1 tracks the fetch whose address is currently presented to the
    // RAM; stage 2 tracks the fetch whose data the RAM is returning.  A flush
    // seen while an entry sits in stage 1 keeps it from reaching stage 2,
    // which is the last point where it can still be cancelled.
    always_ff @(posedge clk) begin
        if (reset) begin
            iram_addr <= '0;
            rr_ptr    <= IDX_W'(NUM_CORES - 1);
            s1_vld    <= 1'b0;
            s1_tag    <= '0;
            s2_vld    <= 1'b0;
            s2_tag    <= '0;
        end else begin
            if (found) begin
                iram_addr <= winner_addr;
                rr_ptr    <= winner;
                s1_vld    <= 1'b1;
                s1_tag    <= winner;
            end else begin
                s1_vld    <= 1'b0;
            end
            s2_vld <= s1_vld & ~flush[s1_tag];
            s2_tag <= s1_tag;
        end
    end

    always_comb begin
        rvalid = '0;
        if (s2_vld) begin
            rvalid[s2_tag] = 1'b1;
        end
    end

    assign rdata = iram_data;

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iram_fetch_arbiter
//
// Directed scenarios followed by a randomized run.  The reference model keeps
// a per-cycle history of grants, flushes and resets and derives each cycle's
// expected grant, rvalid, rdata and iram_addr from that history.
// ---------------------------------------------------------------------------
module tb_iram_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int HIST = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  flush;
    logic [N-1:0]  gnt;
    logic [AW-1:0] iram_addr;
    logic [DW-1:0] iram_data;
    logic [DW-1:0] rdata;
    logic [N-1:0]  rvalid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            cyc = 0;
    int            m_last = N - 1;
    logic [AW-1:0] m_iaddr = '0;
    int            last_w;
    int            h_tag   [HIST];
    logic [AW-1:0] h_addr  [HIST];
    logic [N-1:0]  h_flush [HIST];
    bit            h_rst   [HIST];

    always #5 clk = ~clk;

    iram_fetch_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .flush     (flush),
        .gnt       (gnt),
        .iram_addr (iram_addr),
        .iram_data (iram_data),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = a * 16'd40503;
        return v ^ 16'h5A5A;
    endfunction

    // Instruction RAM: one-cycle registered read
    always @(posedge clk) iram_data <= ram_word(iram_addr);

    function automatic int pick(input logic [N-1:0] elig, input int last);
        for (int k = 1; k <= N; k++) begin
            if (elig[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_winner();
        if (reset) return -1;
        return pick(req & ~flush, m_last);
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] v;
        int w;
        v = '0;
        w = model_winner();
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // A fetch granted two cycles ago returns now unless its owner was flushed
    // or reset was applied in the cycle between.
    function automatic logic [N-1:0] model_rvalid();
        logic [N-1:0] v;
        int t;
        v = '0;
        if (cyc < 2) return v;
        t = h_tag[cyc-2];
        if (t < 0 || h_rst[cyc-1] || h_flush[cyc-1][t]) return v;
        v[t] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] model_rdata();
        return ram_word(h_addr[cyc-2]);
    endfunction

    task automatic set_addr(input int core, input logic [AW-1:0] a);
        req_addr[core*AW +: AW] = a;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Record this cycle in the model, then move to just after the next edge.
    task automatic tick();
        int w;
        w = model_winner();
        h_tag[cyc]   = w;
        h_addr[cyc]  = (w >= 0) ? req_addr[w*AW +: AW] : '0;
        h_flush[cyc] = flush;
        h_rst[cyc]   = reset;
        if (reset) begin
            m_last  = N - 1;
            m_iaddr = '0;
        end else if (w >= 0) begin
            m_last  = w;
            m_iaddr = h_addr[cyc];
        end
        last_w = w;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '1; flush = '0; req_addr = '0;
        @(posedge clk); #1;
        settle();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt0: got %b expected 0000", gnt); end
        tick();
        settle();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt1: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0000", rvalid); end
        checks++; if (iram_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_iram_addr: got %h expected 0000", iram_addr); end
        tick();
        reset = 1'b0; req = '0;
        settle();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL post_reset_rvalid: got %b expected 0000", rvalid); end
        tick();
    endtask

    task automatic test_single_fetch();
        req = 4'b0001; set_addr(0, 16'd5);
        settle();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        settle();
        checks++; if (iram_addr !== 16'd5) begin errors++; $display("[TB] FAIL single_iram_addr: got %0d expected 5", iram_addr); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL single_rvalid_early: got %b expected 0000", rvalid); end
        tick();
        settle();
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL single_rvalid: got %b expected 0001", rvalid); end
        checks++; if (rdata !== ram_word(16'd5)) begin errors++; $display("[TB] FAIL single_rdata: got %h expected %h", rdata, ram_word(16'd5)); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(100 + i));
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            settle();
            if (k < 8) begin
                e = 4'b0001 << (k % 4);
                checks++; if (gnt !== e) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, e); end
            end
            if (k >= 2) begin
                e = 4'b0001 << ((k - 2) % 4);
                checks++; if (rvalid !== e) begin errors++; $display("[TB] FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, e); end
                checks++; if (rdata !== ram_word(AW'(100 + (k - 2) % 4))) begin errors++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, ram_word(AW'(100 + (k - 2) % 4))); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            req = (k < 4) ? 4'b0100 : 4'b0000;
            set_addr(2, AW'(k));
            settle();
            if (k < 4) begin
                checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_gnt[%0d]: got %b expected 0100", k, gnt); end
            end
            if (k >= 2) begin
                checks++; if (rvalid !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b expected 0100", k, rvalid); end
                checks++; if (rdata !== ram_word(AW'(k - 2))) begin errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", k, rdata, ram_word(AW'(k - 2))); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        req = 4'b0010; set_addr(1, 16'd67); flush = '0;
        settle();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL flush_gnt_core1: got %b expected 0010", gnt); end
        tick();
        req = 4'b0001; set_addr(0, 16'h0020); flush = 4'b0010;
        settle();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL flush_gnt_core0: got %b expected 0001", gnt); end
        tick();
        req = '0; flush = '0;
        settle();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL flush_killed: got %b expected 0000", rvalid); end
        tick();
        settle();
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL flush_other_core: got %b expected 0001", rvalid); end
        checks++; if (rdata !== ram_word(16'h0020)) begin errors++; $display("[TB] FAIL flush_other_rdata: got %h expected %h", rdata, ram_word(16'h0020)); end
        tick();
    endtask

    task automatic test_flush_same_cycle();
        req = 4'b0011; flush = 4'b0001;
        set_addr(0, 16'h0030); set_addr(1, 16'h0031);
        settle();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL fsame_gnt: got %b expected 0010", gnt); end
        tick();
        flush = '0;
        settle();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL fsame_ptr_moved: got %b expected 0001", gnt); end
        tick();
        req = '0;
        settle();
        checks++; if (rvalid !== 4'b0010 || rdata !== ram_word(16'h0031)) begin errors++; $display("[TB] FAIL fsame_rvalid1: got %b/%h expected 0010/%h", rvalid, rdata, ram_word(16'h0031)); end
        tick();
        settle();
        checks++; if (rvalid !== 4'b0001 || rdata !== ram_word(16'h0030)) begin errors++; $display("[TB] FAIL fsame_rvalid0: got %b/%h expected 0001/%h", rvalid, rdata, ram_word(16'h0030)); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) set_addr(i, AW'(200 + i));
        req = 4'b1111;
        settle();
        e = model_gnt();
        checks++; if (gnt !== e) begin errors++; $display("[TB] FAIL rmid_gnt_a: got %b expected %b", gnt, e); end
        tick();
        settle();
        tick();
        reset = 1'b1;
        settle();
        e = model_rvalid();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_gnt_in_reset: got %b expected 0000", gnt); end
        checks++; if (rvalid !== e) begin errors++; $display("[TB] FAIL rmid_rvalid_in_reset: got %b expected %b", rvalid, e); end
        tick();
        reset = 1'b0;
        settle();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_rvalid_c1: got %b expected 0000", rvalid); end
        checks++; if (iram_addr !== 16'h0) begin errors++; $display("[TB] FAIL rmid_iram_addr: got %h expected 0000", iram_addr); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_first_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        settle();
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_rvalid_c2: got %b expected 0000", rvalid); end
        tick();
        settle();
        checks++; if (rvalid !== 4'b0001 || rdata !== ram_word(16'd200)) begin errors++; $display("[TB] FAIL rmid_rvalid_c3: got %b/%h expected 0001/%h", rvalid, rdata, ram_word(16'd200)); end
        tick();
    endtask

    task automatic test_random();
        bit            pend [N];
        logic [AW-1:0] paddr [N];
        logic [N-1:0]  eg, ev;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = AW'($urandom_range(0, 65535));
                end
                req[i]   = pend[i];
                set_addr(i, paddr[i]);
                flush[i] = ($urandom_range(0, 9) == 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            settle();
            eg = model_gnt();
            ev = model_rvalid();
            checks++; if (gnt !== eg) begin errors++; $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", cyc, gnt, eg); end
            checks++; if (rvalid !== ev) begin errors++; $display("[TB] FAIL rand_rvalid@%0d: got %b expected %b", cyc, rvalid, ev); end
            checks++; if (iram_addr !== m_iaddr) begin errors++; $display("[TB] FAIL rand_iram_addr@%0d: got %h expected %h", cyc, iram_addr, m_iaddr); end
            if (ev != '0) begin
                checks++; if (rdata !== model_rdata()) begin errors++; $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", cyc, rdata, model_rdata()); end
            end
            tick();
            if (last_w >= 0) pend[last_w] = 1'b0;
        end
        reset = 1'b0; req = '0; flush = '0;
    endtask

    initial begin
        $display("[TB] starting iram_fetch_arbiter bench");
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_back_to_back();
        test_flush();
        test_flush_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
